// File: rtl/ysyx_25030081_lsu.sv
// ysyx_25030081_lsu: load/store unit for the single-issue NPC core.
// It takes one memory request at a time from the core, issues it on a simple
// valid/ready data-memory bus and returns extended load data (or an error) as
// a one-cycle response pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses take the error path
//   undefined -> no alignment check; only illegal funct3 values are errors
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        core request handshake
//   req_wr, req_op             store flag and RV32I funct3
//   req_addr, req_wdata        byte address and LSB-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data / error flag (held until next response)
//   mem_req_valid/mem_req_ready bus request handshake
//   mem_addr, mem_wen          word-aligned address, write enable
//   mem_wstrb, mem_wdata       byte strobes, lane-replicated store data
//   mem_resp_valid, mem_rdata  bus completion and read word
module ysyx_25030081_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic          req_ready_q,     req_ready_d;
  logic          resp_valid_q,    resp_valid_d;
  logic [DW-1:0] resp_rdata_q,    resp_rdata_d;
  logic          resp_err_q,      resp_err_d;
  logic          mem_req_valid_q, mem_req_valid_d;
  logic [AW-1:0] mem_addr_q,      mem_addr_d;
  logic          mem_wen_q,       mem_wen_d;
  logic [SW-1:0] mem_wstrb_q,     mem_wstrb_d;
  logic [DW-1:0] mem_wdata_q,     mem_wdata_d;
  logic [2:0]    op_q,            op_d;
  logic [1:0]    off_q,           off_d;

  logic          illegal_c;
  logic          misalign_c;
  logic [SW-1:0] strb_c;
  logic [DW-1:0] lane_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [DW-1:0] load_c;

  // Request decode: legality, alignment, strobes and replicated store lanes.
  always_comb begin
    illegal_c  = 1'b0;
    misalign_c = 1'b0;
    strb_c     = '0;
    lane_c     = '0;
    case (req_op)
      OP_B: begin
        strb_c = SW'(4'b0001 << req_addr[1:0]);
        lane_c = {4{req_wdata[7:0]}};
      end
      OP_H: begin
        strb_c = SW'(4'b0011 << {req_addr[1], 1'b0});
        lane_c = {2{req_wdata[15:0]}};
      end
      OP_W: begin
        strb_c = 4'b1111;
        lane_c = req_wdata;
      end
      OP_BU, OP_HU: illegal_c = req_wr;
      default:      illegal_c = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_op)
      OP_H, OP_HU: misalign_c = req_addr[0];
      OP_W:        misalign_c = |req_addr[1:0];
      default:     misalign_c = 1'b0;
    endcase
`endif
    // Loads never drive strobes or write data onto the bus.
    if (!req_wr) begin
      strb_c = '0;
      lane_c = '0;
    end
  end

  // Load extraction from the returned word using the latched op and offset.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_B:    load_c = {{24{byte_c[7]}}, byte_c};
      OP_BU:   load_c = {24'h0, byte_c};
      OP_H:    load_c = {{16{half_c[15]}}, half_c};
      OP_HU:   load_c = {16'h0, half_c};
      OP_W:    load_c = mem_rdata;
      default: load_c = '0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_addr_d    = mem_addr_q;
    mem_wen_d     = mem_wen_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    op_d          = op_q;
    off_d         = off_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = req_op;
          off_d       = req_addr[1:0];
          mem_addr_d  = {req_addr[AW-1:2], 2'b00};
          mem_wstrb_d = strb_c;
          mem_wdata_d = lane_c;
          // Rejected requests never reach the bus, so keep the write enable low.
          mem_wen_d   = req_wr & ~(illegal_c | misalign_c);
          if (illegal_c || misalign_c) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_wen_q ? '0 : load_c;
          state_d      = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    req_ready_d     = (state_d == S_IDLE);
    mem_req_valid_d = (state_d == S_REQ);
    resp_valid_d    = (state_d == S_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wstrb_q     <= '0;
      mem_wdata_q     <= '0;
      op_q            <= '0;
      off_q           <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wstrb_q     <= mem_wstrb_d;
      mem_wdata_q     <= mem_wdata_d;
      op_q            <= op_d;
      off_q           <= off_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Directed bench for ysyx_25030081_lsu with a response scoreboard.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ysyx_25030081_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; expected response goes into the scoreboard when driven
  // and is popped when the DUT pulses resp_valid.
  task automatic access(input string tag, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    exp_t e;
    exp_t got;
    int   n;
    logic [31:0] exp_addr;
    exp_addr = addr & ~32'h3;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);

    @(negedge clk);
    chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    // Scramble request inputs; the DUT must use its latched copy.
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;

    if (!exp_err) begin
      chk({tag, "/mem_req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, "/mem_addr"}, mem_addr, exp_addr);
      chk({tag, "/mem_wen"}, 32'(mem_wen), 32'(wr));
      chk({tag, "/mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
      if (wr) chk({tag, "/mem_wdata"}, mem_wdata, exp_wdata);
      repeat (rdy_dly) begin
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk({tag, "/stall_stable"},
            32'(mem_req_valid && mem_addr == exp_addr && mem_wstrb == exp_strb &&
                mem_wen == wr && !req_ready && !resp_valid), 32'd1);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({tag, "/wait_no_req"}, 32'(mem_req_valid), 32'd0);
      repeat (rsp_dly) begin
        @(negedge clk);
        chk({tag, "/wait_no_resp"}, 32'(resp_valid | req_ready), 32'd0);
      end
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_rdata      = $urandom;
    end else begin
      chk({tag, "/no_bus"}, 32'(mem_req_valid), 32'd0);
    end

    n = 0;
    while (!resp_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/resp_latency"}, 32'(n), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, "/resp_rdata"}, resp_rdata, got.rdata);
      chk({tag, "/resp_err"}, 32'(resp_err), 32'(got.err));
    end
    @(negedge clk);
    chk({tag, "/single_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, "/rdata_hold"}, resp_rdata, exp_rdata);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_wr         = 1'b0;
    req_op         = 3'b000;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    @(negedge clk);
    chk("reset/ctrl", 32'({req_ready, resp_valid, resp_err, mem_req_valid, mem_wen}), 32'h10);
    chk("reset/resp_rdata", resp_rdata, 32'h0);
    chk("reset/mem_addr", mem_addr, 32'h0);
    chk("reset/mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("reset/mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    //      tag      wr    op      addr          wdata         rdata        rdy rsp err exp_rdata     strb     exp_wdata
    access("lb",     1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
    access("lhu",    1'b0, 3'b101, 32'h8000_0002, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 32'h0000_80FF, 4'b0000, 32'h0);
    access("sb",     1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB);
    access("lh_stl", 1'b0, 3'b001, 32'h8000_0000, 32'h0,        32'h0000_8001, 3, 2, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
    access("sh",     1'b1, 3'b001, 32'h8000_0006, 32'h0000_BEEF, 32'h1111_1111, 1, 1, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF);
    access("sw",     1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        0, 0, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D);
    access("lbu",    1'b0, 3'b100, 32'h8000_0002, 32'h0,        32'h11AA_2233, 0, 0, 1'b0, 32'h0000_00AA, 4'b0000, 32'h0);
    access("lb_pos", 1'b0, 3'b000, 32'h8000_0001, 32'h0,        32'h11AA_2233, 0, 3, 1'b0, 32'h0000_0022, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0);
    access("sh_mis", 1'b1, 3'b001, 32'h8000_0001, 32'h0000_1234, 32'h0,       0, 0, 1'b1, 32'h0,         4'b0000, 32'h0);
`else
    access("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'h89AB_CDEF, 0, 0, 1'b0, 32'h89AB_CDEF, 4'b0000, 32'h0);
    access("lh_odd", 1'b0, 3'b001, 32'h8000_0003, 32'h0,        32'h7FFF_0001, 0, 0, 1'b0, 32'h0000_7FFF, 4'b0000, 32'h0);
`endif
    access("ld_011", 1'b0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,         4'b0000, 32'h0);
    access("st_100", 1'b1, 3'b100, 32'h8000_0000, 32'h5555_5555, 32'h0,       0, 0, 1'b1, 32'h0,         4'b0000, 32'h0);
    access("lw_ok",  1'b0, 3'b010, 32'h8000_0010, 32'h0,        32'h0BAD_F00D, 0, 0, 1'b0, 32'h0BAD_F00D, 4'b0000, 32'h0);

    // Asynchronous reset while waiting for the bus response.
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'h8000_0020;
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    chk("rst/pre_req", 32'(mem_req_valid), 32'd1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst/in_wait", 32'(req_ready | mem_req_valid | resp_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst/ctrl", 32'({req_ready, resp_valid, resp_err, mem_req_valid, mem_wen}), 32'h10);
    chk("rst/mem_addr", mem_addr, 32'h0);
    chk("rst/resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    n = 0;
    repeat (4) begin
      if (resp_valid) n++;
      @(negedge clk);
    end
    chk("rst/late_resp_ignored", 32'(n), 32'd0);
    chk("rst/idle_ready", 32'(req_ready), 32'd1);

    access("post_rst", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8000_7FFF, 0, 0, 1'b0, 32'hFFFF_8000, 4'b0000, 32'h0);
    chk("sb/drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
